// File: rtl/axi_mem_pkg.sv
// ---------------------------------------------------------------------------
// axi_mem_pkg
// Shared types for the AXI-style slave memory:
//   TAG_W      - width of the optional read-data tag (upper address bits)
//   wr_state_t - write-channel FSM states
//   rd_req_t   - one queued read request {id, index, tag}
// The request fields are sized to fixed upper bounds so that the package does
// not depend on module parameters; the top zero-extends into them and slices
// back out. ID_W and MEM_LOG2 must not exceed ID_MAX_W / IDX_MAX_W.
// ---------------------------------------------------------------------------
package axi_mem_pkg;

  localparam int TAG_W     = 64;
  localparam int ID_MAX_W  = 32;
  localparam int IDX_MAX_W = 32;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef struct packed {
    logic [ID_MAX_W-1:0]  id;
    logic [IDX_MAX_W-1:0] index;
    logic [TAG_W-1:0]     tag;
  } rd_req_t;

  localparam int RD_REQ_W = $bits(rd_req_t);

endpackage

// File: rtl/axi_req_fifo.sv
// ---------------------------------------------------------------------------
// axi_req_fifo
// Small synchronous FIFO holding outstanding read requests.
//   clk, rst  - clock, asynchronous active-high reset (pointers/count only)
//   push_i    - write data_i (ignored when full unless popping the same cycle)
//   data_i    - entry to enqueue
//   pop_i     - drop the head entry (ignored when empty)
//   data_o    - current head entry (valid while !empty_o)
//   full_o    - DEPTH entries held
//   empty_o   - no entries held
// A push and a pop in the same cycle while full leave occupancy unchanged.
// ---------------------------------------------------------------------------
module axi_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_pop   = pop_i && !empty_o;
  // When full, the slot being vacated by the pop is the one the push lands in.
  assign w_push  = push_i && (!full_o || w_pop);
  assign data_o  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/axi_slave_mem_pipe.sv
// ---------------------------------------------------------------------------
// axi_slave_mem_pipe
// AXI-style slave backed by an internal beat-wide memory.
//   clk, rst                        - clock, asynchronous active-high reset
//   arid_i/araddr_i/arvalid_i/arready_o - read request channel
//   rid_o/rdata_o/rvalid_o/rready_i     - read response channel
//   awid_i/awaddr_i/awvalid_i/awready_o - write address channel
//   wdata_i/wstrb_i/wvalid_i/wready_o   - write data channel (byte strobes)
//   bid_o/bvalid_o/bready_i             - write response channel
// Reads are queued (RQ_DEPTH deep) and each returns RD_LAT cycles after its
// request reaches the queue head, in acceptance order. Writes run one at a
// time through a three-state FSM. Memory contents survive reset.
// Optional feature: define AXI_SLAVE_MEM_TAG_EN to prepend TAG_W bits of the
// read address above the indexed range to rdata_o.
// ---------------------------------------------------------------------------
module axi_slave_mem_pipe
  import axi_mem_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 512,
  parameter int ID_W     = 16,
  parameter int MEM_LOG2 = 20,
  parameter int RD_LAT   = 4,
  parameter int RQ_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     arid_i,
  input  logic [ADDR_W-1:0]   araddr_i,
  input  logic                arvalid_i,
  output logic                arready_o,
  output logic [ID_W-1:0]     rid_o,
`ifdef AXI_SLAVE_MEM_TAG_EN
  output logic [TAG_W+DATA_W-1:0] rdata_o,
`else
  output logic [DATA_W-1:0]   rdata_o,
`endif
  output logic                rvalid_o,
  input  logic                rready_i,
  input  logic [ID_W-1:0]     awid_i,
  input  logic [ADDR_W-1:0]   awaddr_i,
  input  logic                awvalid_i,
  output logic                awready_o,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  output logic [ID_W-1:0]     bid_o,
  output logic                bvalid_o,
  input  logic                bready_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = $clog2(RD_LAT + 1);
`ifdef AXI_SLAVE_MEM_TAG_EN
  localparam int RDW = TAG_W + DATA_W;
`else
  localparam int RDW = DATA_W;
`endif

  logic [DATA_W-1:0] r_mem [1 << MEM_LOG2];

  // ---- read request queue ----
  rd_req_t             w_ar_req;
  rd_req_t             w_head;
  logic                w_q_full;
  logic                w_q_empty;
  logic                w_push;
  logic                w_pop;
  logic [MEM_LOG2-1:0] w_ar_idx;
  logic [MEM_LOG2-1:0] w_head_idx;

  // Beat index: byte offset dropped, upper address bits ignored (aliasing).
  assign w_ar_idx = araddr_i[OFF_W +: MEM_LOG2];

  always_comb begin
    w_ar_req       = '0;
    w_ar_req.id    = ID_MAX_W'(arid_i);
    w_ar_req.index = IDX_MAX_W'(w_ar_idx);
`ifdef AXI_SLAVE_MEM_TAG_EN
    w_ar_req.tag   = TAG_W'(araddr_i >> (MEM_LOG2 + OFF_W));
`endif
  end

  assign arready_o = !w_q_full;
  assign w_push    = arvalid_i && arready_o;
  assign w_pop     = rvalid_o && rready_i;

  axi_req_fifo #(
    .WIDTH (RD_REQ_W),
    .DEPTH (RQ_DEPTH)
  ) u_rq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .data_i  (w_ar_req),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_q_full),
    .empty_o (w_q_empty)
  );

  // ---- read response: head latency counter and output register ----
  logic             r_rvalid;
  logic [ID_W-1:0]  r_rid;
  logic [RDW-1:0]   r_rdata;
  logic [CNT_W-1:0] r_cnt;
  logic             w_fire;
  logic [RDW-1:0]   w_rd_word;

  assign w_head_idx = w_head.index[MEM_LOG2-1:0];
`ifdef AXI_SLAVE_MEM_TAG_EN
  assign w_rd_word = {w_head.tag, r_mem[w_head_idx]};
`else
  assign w_rd_word = r_mem[w_head_idx];
`endif

  // The counter advances once per cycle the head waits, so the RD_LAT-th
  // edge after the entry became head both raises rvalid and samples memory.
  assign w_fire = !w_q_empty && !r_rvalid && (r_cnt == CNT_W'(RD_LAT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rid    <= '0;
      r_rdata  <= '0;
      r_cnt    <= '0;
    end else if (w_pop) begin
      r_rvalid <= 1'b0;
      r_cnt    <= '0;
    end else if (w_fire) begin
      r_rvalid <= 1'b1;
      r_cnt    <= '0;
      r_rid    <= w_head.id[ID_W-1:0];
      r_rdata  <= w_rd_word;
    end else if (!w_q_empty && !r_rvalid) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign rvalid_o = r_rvalid;
  assign rid_o    = r_rid;
  assign rdata_o  = r_rdata;

  // ---- write FSM ----
  wr_state_t           r_wstate;
  wr_state_t           w_wstate_nxt;
  logic [ID_W-1:0]     r_awid;
  logic [MEM_LOG2-1:0] r_widx;
  logic                w_aw_hs;
  logic                w_w_hs;

  always_comb begin
    w_wstate_nxt = r_wstate;
    awready_o    = 1'b0;
    wready_o     = 1'b0;
    bvalid_o     = 1'b0;
    w_aw_hs      = 1'b0;
    w_w_hs       = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        awready_o = 1'b1;
        if (awvalid_i) begin
          w_aw_hs      = 1'b1;
          w_wstate_nxt = W_DATA;
        end
      end
      W_DATA: begin
        wready_o = 1'b1;
        if (wvalid_i) begin
          w_w_hs       = 1'b1;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        bvalid_o = 1'b1;
        if (bready_i) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_awid   <= '0;
      r_widx   <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_aw_hs) begin
        r_awid <= awid_i;
        r_widx <= awaddr_i[OFF_W +: MEM_LOG2];
      end
    end
  end

  assign bid_o = r_awid;

  // Memory has no reset. A commit here and a read sample above on the same
  // edge to the same index give the reader the pre-commit contents.
  always_ff @(posedge clk) begin
    if (w_w_hs) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_i[b]) r_mem[r_widx][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  // Address bits outside the indexed range and the unused request fields.
  logic w_unused_ok;
  assign w_unused_ok = ^{awaddr_i, araddr_i, w_head};

endmodule

// File: tb/tb_axi_slave_mem_pipe.sv
module tb_axi_slave_mem_pipe;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 512;
  localparam int ID_W     = 8;
  localparam int MEM_LOG2 = 4;
  localparam int RD_LAT   = 4;
  localparam int RQ_DEPTH = 4;
  localparam int STRB_W   = DATA_W / 8;
  localparam int BEATS    = 1 << MEM_LOG2;
`ifdef AXI_SLAVE_MEM_TAG_EN
  localparam int RDW = 64 + DATA_W;
`else
  localparam int RDW = DATA_W;
`endif

  logic              clk;
  logic              rst;
  logic [ID_W-1:0]   arid_i;
  logic [ADDR_W-1:0] araddr_i;
  logic              arvalid_i;
  logic              arready_o;
  logic [ID_W-1:0]   rid_o;
  logic [RDW-1:0]    rdata_o;
  logic              rvalid_o;
  logic              rready_i;
  logic [ID_W-1:0]   awid_i;
  logic [ADDR_W-1:0] awaddr_i;
  logic              awvalid_i;
  logic              awready_o;
  logic [DATA_W-1:0] wdata_i;
  logic [STRB_W-1:0] wstrb_i;
  logic              wvalid_i;
  logic              wready_o;
  logic [ID_W-1:0]   bid_o;
  logic              bvalid_o;
  logic              bready_i;

  axi_slave_mem_pipe #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
    .MEM_LOG2(MEM_LOG2), .RD_LAT(RD_LAT), .RQ_DEPTH(RQ_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .arid_i(arid_i), .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bvalid_o(bvalid_o), .bready_i(bready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  // Reference memory: one entry per beat, updated byte-wise on each write.
  logic [DATA_W-1:0] model [BEATS];

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } rsp_t;
  rsp_t exp_q[$];

  function automatic int beat_of(input logic [ADDR_W-1:0] a);
    return int'((a / STRB_W) % BEATS);
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic void model_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                      input logic [STRB_W-1:0] s);
    int k;
    k = beat_of(a);
    for (int b = 0; b < STRB_W; b++)
      if (s[b]) model[k][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id,
                          input logic [DATA_W-1:0] data, input logic [STRB_W-1:0] strb);
    int c;
    awaddr_i = addr; awid_i = id; awvalid_i = 1'b1;
    c = 0;
    while (!awready_o && c < 50) begin step(); c++; end
    step();
    awvalid_i = 1'b0;
    wdata_i = data; wstrb_i = strb; wvalid_i = 1'b1;
    c = 0;
    while (!wready_o && c < 50) begin step(); c++; end
    step();
    wvalid_i = 1'b0;
    model_write(addr, data, strb);
    c = 0;
    while (!bvalid_o && c < 50) begin step(); c++; end
    n_checks++;
    if (bvalid_o !== 1'b1 || bid_o !== id) begin
      n_errors++;
      $display("FAIL write_bresp addr=%0h: bvalid=%b bid=%0h, expected bvalid=1 bid=%0h",
               addr, bvalid_o, bid_o, id);
    end
    bready_i = 1'b1;
    step();
    bready_i = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id,
                         output logic [DATA_W-1:0] got);
    int c, t0;
    logic [DATA_W-1:0] exp;
    exp = model[beat_of(addr)];
    araddr_i = addr; arid_i = id; arvalid_i = 1'b1;
    c = 0;
    while (!arready_o && c < 50) begin step(); c++; end
    step();
    arvalid_i = 1'b0;
    t0 = cyc;
    c = 0;
    while (!rvalid_o && c < 50) begin step(); c++; end
    n_checks++;
    if (cyc - t0 != RD_LAT) begin
      n_errors++;
      $display("FAIL read_latency addr=%0h: got %0d cycles, expected %0d", addr, cyc - t0, RD_LAT);
    end
    got = rdata_o[DATA_W-1:0];
    n_checks++;
    if (rid_o !== id || got !== exp) begin
      n_errors++;
      $display("FAIL read_data addr=%0h: rid=%0h data=%h, expected rid=%0h data=%h",
               addr, rid_o, got, id, exp);
    end
    rready_i = 1'b1;
    step();
    rready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    arid_i = '0; araddr_i = '0; arvalid_i = 1'b0; rready_i = 1'b0;
    awid_i = '0; awaddr_i = '0; awvalid_i = 1'b0;
    wdata_i = '0; wstrb_i = '0; wvalid_i = 1'b0; bready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (rvalid_o !== 1'b0) begin n_errors++; $display("FAIL reset_rvalid: got %b, expected 0", rvalid_o); end
    n_checks++; if (bvalid_o !== 1'b0) begin n_errors++; $display("FAIL reset_bvalid: got %b, expected 0", bvalid_o); end
    n_checks++; if (wready_o !== 1'b0) begin n_errors++; $display("FAIL reset_wready: got %b, expected 0", wready_o); end
    n_checks++; if (rid_o !== '0) begin n_errors++; $display("FAIL reset_rid: got %0h, expected 0", rid_o); end
    n_checks++; if (bid_o !== '0) begin n_errors++; $display("FAIL reset_bid: got %0h, expected 0", bid_o); end
    n_checks++; if (rdata_o !== '0) begin n_errors++; $display("FAIL reset_rdata: nonzero, expected 0"); end
    rst = 1'b0;
    step();
    n_checks++; if (arready_o !== 1'b1) begin n_errors++; $display("FAIL reset_arready: got %b, expected 1", arready_o); end
    n_checks++; if (awready_o !== 1'b1) begin n_errors++; $display("FAIL reset_awready: got %b, expected 1", awready_o); end
  endtask

  task automatic test_init();
    for (int i = 0; i < BEATS; i++)
      do_write(ADDR_W'(i * STRB_W), ID_W'($urandom), rand_data(), '1);
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] pat, got;
    pat = {STRB_W{8'hA5}};
    do_write(32'h40, 8'h3C, pat, '1);
    do_read(32'h40, 8'h5A, got);
    n_checks++;
    if (got !== pat) begin n_errors++; $display("FAIL basic_a5: got %h, expected %h", got, pat); end
  endtask

  task automatic test_strobe();
    logic [DATA_W-1:0] got, want;
    logic [STRB_W-1:0] s1;
    s1 = '0; s1[0] = 1'b1;
    want = '0; want[7:0] = 8'hFF;
    do_write(32'h80, 8'h11, '0, '1);
    do_write(32'h80, 8'h12, {STRB_W{8'hFF}}, s1);
    do_read(32'h80, 8'h13, got);
    n_checks++;
    if (got !== want) begin n_errors++; $display("FAIL strobe_byte0: got %h, expected %h", got, want); end
  endtask

  task automatic test_random(input int n);
    logic [DATA_W-1:0] got;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 0)
        do_write($urandom, ID_W'($urandom), rand_data(), {$urandom, $urandom});
      else
        do_read($urandom, ID_W'($urandom), got);
    end
  endtask

  task automatic test_alias();
    logic [DATA_W-1:0] d, got;
    d = rand_data();
    do_write(ADDR_W'(1) << (MEM_LOG2 + 6), 8'h21, d, '1);
    do_read(32'h0, 8'h22, got);
    n_checks++;
    if (got !== d) begin n_errors++; $display("FAIL alias_beat0: got %h, expected %h", got, d); end
  endtask

  task automatic test_queue_full();
    rsp_t e;
    logic [ADDR_W-1:0] a5;
    int got_n;
    bit ar_done;
    rready_i = 1'b0;
    exp_q.delete();
    for (int k = 0; k < RQ_DEPTH; k++) begin
      araddr_i = $urandom; arid_i = ID_W'(k + 1); arvalid_i = 1'b1;
      n_checks++;
      if (arready_o !== 1'b1) begin n_errors++; $display("FAIL qfull_accept%0d: arready=%b, expected 1", k, arready_o); end
      e.id = arid_i; e.data = model[beat_of(araddr_i)];
      exp_q.push_back(e);
      step();
    end
    a5 = $urandom;
    araddr_i = a5; arid_i = 8'h55; arvalid_i = 1'b1;
    n_checks++;
    if (arready_o !== 1'b0) begin n_errors++; $display("FAIL qfull_arready: got %b, expected 0", arready_o); end
    repeat (3) step();
    n_checks++;
    if (arready_o !== 1'b0 || rvalid_o !== 1'b1) begin
      n_errors++; $display("FAIL qfull_hold: arready=%b rvalid=%b, expected 0 and 1", arready_o, rvalid_o);
    end
    rready_i = 1'b1;
    got_n = 0; ar_done = 0;
    for (int c = 0; c < 200 && got_n < RQ_DEPTH + 1; c++) begin
      if (rvalid_o) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++; $display("FAIL qfull_extra: unexpected response rid=%0h", rid_o);
        end else begin
          e = exp_q.pop_front();
          if (rid_o !== e.id || rdata_o[DATA_W-1:0] !== e.data) begin
            n_errors++;
            $display("FAIL qfull_order%0d: rid=%0h data=%h, expected rid=%0h data=%h",
                     got_n, rid_o, rdata_o[DATA_W-1:0], e.id, e.data);
          end
        end
        got_n++;
      end
      if (arvalid_i && arready_o) begin
        e.id = 8'h55; e.data = model[beat_of(a5)];
        exp_q.push_back(e);
        ar_done = 1;
      end
      step();
      if (ar_done) arvalid_i = 1'b0;
    end
    rready_i = 1'b0;
    arvalid_i = 1'b0;
    n_checks++;
    if (got_n != RQ_DEPTH + 1) begin n_errors++; $display("FAIL qfull_count: got %0d responses, expected %0d", got_n, RQ_DEPTH + 1); end
  endtask

  task automatic test_back_to_back(input int n);
    rsp_t e;
    int issued, got_n;
    bit pushed;
    exp_q.delete();
    issued = 0; got_n = 0;
    araddr_i = $urandom; arid_i = ID_W'($urandom); arvalid_i = 1'b1;
    for (int c = 0; c < 2000 && got_n < n; c++) begin
      rready_i = $urandom_range(0, 1);
      pushed = 0;
      if (rvalid_o && rready_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++; $display("FAIL b2b_extra: unexpected response rid=%0h", rid_o);
        end else begin
          e = exp_q.pop_front();
          if (rid_o !== e.id || rdata_o[DATA_W-1:0] !== e.data) begin
            n_errors++;
            $display("FAIL b2b_resp%0d: rid=%0h data=%h, expected rid=%0h data=%h",
                     got_n, rid_o, rdata_o[DATA_W-1:0], e.id, e.data);
          end
        end
        got_n++;
      end
      if (arvalid_i && arready_o) begin
        e.id = arid_i; e.data = model[beat_of(araddr_i)];
        exp_q.push_back(e);
        issued++;
        pushed = 1;
      end
      step();
      if (pushed) begin
        if (issued < n) begin araddr_i = $urandom; arid_i = ID_W'($urandom); end
        else arvalid_i = 1'b0;
      end
    end
    arvalid_i = 1'b0;
    rready_i = 1'b0;
    n_checks++;
    if (got_n != n) begin n_errors++; $display("FAIL b2b_count: got %0d responses, expected %0d", got_n, n); end
  endtask

  task automatic test_same_cycle();
    logic [DATA_W-1:0] old_d, new_d, got;
    int c;
    old_d = model[3];
    new_d = rand_data();
    awaddr_i = 32'd3 * STRB_W; awid_i = 8'h33; awvalid_i = 1'b1;
    c = 0;
    while (!awready_o && c < 50) begin step(); c++; end
    step();
    awvalid_i = 1'b0;
    araddr_i = 32'd3 * STRB_W; arid_i = 8'h34; arvalid_i = 1'b1;
    n_checks++;
    if (arready_o !== 1'b1) begin n_errors++; $display("FAIL same_arready: got %b, expected 1", arready_o); end
    step();
    arvalid_i = 1'b0;
    repeat (RD_LAT - 1) step();
    wdata_i = new_d; wstrb_i = '1; wvalid_i = 1'b1;
    step();
    wvalid_i = 1'b0;
    n_checks++;
    if (rvalid_o !== 1'b1 || rdata_o[DATA_W-1:0] !== old_d) begin
      n_errors++;
      $display("FAIL same_old: rvalid=%b data=%h, expected rvalid=1 data=%h", rvalid_o, rdata_o[DATA_W-1:0], old_d);
    end
    model_write(32'd3 * STRB_W, new_d, '1);
    rready_i = 1'b1; step(); rready_i = 1'b0;
    c = 0;
    while (!bvalid_o && c < 50) begin step(); c++; end
    n_checks++;
    if (bvalid_o !== 1'b1 || bid_o !== 8'h33) begin
      n_errors++; $display("FAIL same_bresp: bvalid=%b bid=%0h, expected 1 and 33", bvalid_o, bid_o);
    end
    bready_i = 1'b1; step(); bready_i = 1'b0;
    do_read(32'd3 * STRB_W, 8'h35, got);
    n_checks++;
    if (got !== new_d) begin n_errors++; $display("FAIL same_new: got %h, expected %h", got, new_d); end
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] d5, got;
    int c;
    d5 = rand_data();
    awaddr_i = 32'd5 * STRB_W; awid_i = 8'h45; awvalid_i = 1'b1;
    c = 0;
    while (!awready_o && c < 50) begin step(); c++; end
    step();
    awvalid_i = 1'b0;
    wdata_i = d5; wstrb_i = '1; wvalid_i = 1'b1;
    step();
    wvalid_i = 1'b0;
    model_write(32'd5 * STRB_W, d5, '1);
    n_checks++;
    if (bvalid_o !== 1'b1) begin n_errors++; $display("FAIL rmid_wresp: bvalid=%b, expected 1", bvalid_o); end
    rready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      araddr_i = (32'd6 + k) * STRB_W; arid_i = ID_W'(8'h60 + k); arvalid_i = 1'b1;
      step();
    end
    arvalid_i = 1'b0;
    repeat (RD_LAT) step();
    n_checks++;
    if (rvalid_o !== 1'b1 || bvalid_o !== 1'b1) begin
      n_errors++; $display("FAIL rmid_before: rvalid=%b bvalid=%b, expected 1 and 1", rvalid_o, bvalid_o);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (rvalid_o !== 1'b0 || bvalid_o !== 1'b0) begin
      n_errors++; $display("FAIL rmid_drop: rvalid=%b bvalid=%b, expected 0 and 0", rvalid_o, bvalid_o);
    end
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (arready_o !== 1'b1 || awready_o !== 1'b1) begin
      n_errors++; $display("FAIL rmid_ready: arready=%b awready=%b, expected 1 and 1", arready_o, awready_o);
    end
    repeat (RD_LAT + 2) step();
    n_checks++;
    if (rvalid_o !== 1'b0) begin n_errors++; $display("FAIL rmid_qempty: rvalid=%b, expected 0", rvalid_o); end
    do_read(32'd5 * STRB_W, 8'h70, got);
    n_checks++;
    if (got !== d5) begin n_errors++; $display("FAIL rmid_retained: got %h, expected %h", got, d5); end
    do_read(32'd6 * STRB_W, 8'h71, got);
  endtask

  initial begin
    test_reset();
    test_init();
    test_basic();
    test_strobe();
    test_random(40);
    test_alias();
    test_queue_full();
    test_back_to_back(24);
    test_same_cycle();
    test_reset_mid();
    test_random(20);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors so far", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
